serial_word_deserializer: RTL and testbench

//  Bit-serial to WIDTH-bit parallel converter; the expanding counterpart of the bit-reducing gate library.

---
 rtl/serial_word_deserializer.sv | 202 ++++++++++++++++++++
 tb/tb_serial_word_deserializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
// Bit-serial to WIDTH-bit parallel converter with valid/ready handshakes on
// both sides. The shift register keeps filling while the previous word waits
// in the output buffer. A word that completes while the buffer is still
// occupied is parked in the shift register (FULL state) until the buffer is
// taken.
// Optional feature macro: PARITY_CHECK_EN -- each frame carries one trailing
// even-parity bit and parity_err reports the check result with each word.
// Without the macro, frames are exactly WIDTH bits and parity_err is 0.

module serial_word_deserializer #(
   parameter int WIDTH     = 16,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sync,
   input  logic             ser_valid,
   input  logic             ser_bit,
   output logic             ser_ready,
   output logic             word_valid,
   input  logic             word_ready,
   output logic [WIDTH-1:0] word_data,
   output logic             parity_err
);

`ifdef PARITY_CHECK_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   // Frame length and bit counter sizing
   localparam int N  = WIDTH + PAR;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {
      SHIFT = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             ready_q, ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;

`ifdef PARITY_CHECK_EN
   logic             par_q, par_d;
   logic             hold_err_q, hold_err_d;
   logic             out_err_q, out_err_d;
   logic             err;
`endif

   logic             accept;
   logic             take;
   logic             load;
   logic [WIDTH-1:0] word;

   // Insert one received bit at the end selected by MSB_FIRST
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                 input logic             b);
      if (MSB_FIRST != 0)
         return {s[WIDTH-2:0], b};
      else
         return {b, s[WIDTH-1:1]};
   endfunction

   // Next-state, counter, shift register and output buffer update
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      shreg_d     = shreg_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      load        = 1'b0;
      word        = shreg_q;
`ifdef PARITY_CHECK_EN
      par_d       = par_q;
      hold_err_d  = hold_err_q;
      out_err_d   = out_err_q;
      err         = 1'b0;
`endif
      accept      = ser_valid & ready_q;
      take        = out_valid_q & word_ready;

      case (state_q)
         SHIFT: begin
            if (sync) begin
               // Drop the partial word; a bit accepted now starts the new one
               count_d = '0;
`ifdef PARITY_CHECK_EN
               par_d   = 1'b0;
`endif
               if (accept) begin
                  count_d = CW'(1);
                  shreg_d = shift_in(shreg_q, ser_bit);
`ifdef PARITY_CHECK_EN
                  par_d   = ser_bit;
`endif
               end
            end else if (accept) begin
               if (count_q == LAST) begin
                  count_d = '0;
`ifdef PARITY_CHECK_EN
                  // Last bit is the parity bit: data is already complete
                  word  = shreg_q;
                  err   = par_q ^ ser_bit;
                  par_d = 1'b0;
`else
                  word  = shift_in(shreg_q, ser_bit);
`endif
                  if (!out_valid_q || take) begin
                     load = 1'b1;
                  end else begin
                     // Output busy: park the finished word until it is taken
                     state_d = FULL;
                     shreg_d = word;
`ifdef PARITY_CHECK_EN
                     hold_err_d = err;
`endif
                  end
               end else begin
                  count_d = count_q + CW'(1);
                  shreg_d = shift_in(shreg_q, ser_bit);
`ifdef PARITY_CHECK_EN
                  par_d   = par_q ^ ser_bit;
`endif
               end
            end
         end
         FULL: begin
            if (take) begin
               load    = 1'b1;
               word    = shreg_q;
`ifdef PARITY_CHECK_EN
               err     = hold_err_q;
`endif
               state_d = SHIFT;
               count_d = '0;
            end
         end
         default: begin
            state_d = SHIFT;
         end
      endcase

      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = word;
`ifdef PARITY_CHECK_EN
         out_err_d   = err;
`endif
      end else if (take) begin
         out_valid_d = 1'b0;
      end

      // Registered so ser_ready never sees word_ready combinationally
      ready_d = (state_d == SHIFT);
   end

   // State register; reset clears everything including buffered data
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SHIFT;
         count_q     <= '0;
         shreg_q     <= '0;
         ready_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef PARITY_CHECK_EN
         par_q       <= 1'b0;
         hold_err_q  <= 1'b0;
         out_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         shreg_q     <= shreg_d;
         ready_q     <= ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef PARITY_CHECK_EN
         par_q       <= par_d;
         hold_err_q  <= hold_err_d;
         out_err_q   <= out_err_d;
`endif
      end
   end

   assign ser_ready  = ready_q;
   assign word_valid = out_valid_q;
   assign word_data  = out_data_q;
`ifdef PARITY_CHECK_EN
   assign parity_err = out_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Testbench for serial_word_deserializer (WIDTH=16, MSB_FIRST=1).
// Inputs are driven on the falling edge; a monitor checks every word take
// against a queue of words predicted from the received bit stream.

module tb_serial_word_deserializer;

   localparam int WIDTH = 16;
`ifdef PARITY_CHECK_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             sync = 1'b0;
   logic             ser_valid = 1'b0;
   logic             ser_bit = 1'b0;
   logic             ser_ready;
   logic             word_valid;
   logic             word_ready = 1'b0;
   logic [WIDTH-1:0] word_data;
   logic             parity_err;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   logic partial[$];

   serial_word_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .sync       (sync),
      .ser_valid  (ser_valid),
      .ser_bit    (ser_bit),
      .ser_ready  (ser_ready),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: collect frame bits; a full frame becomes one word
   task automatic model_step(input logic rdy, input logic v, input logic b, input logic s);
      exp_t e;
      logic x;
      if (rdy) begin
         if (s) partial.delete();
         if (v) begin
            partial.push_back(b);
            if (partial.size() == N) begin
               e.data = '0;
               x = 1'b0;
               for (int i = 0; i < WIDTH; i++)
                  e.data = e.data | (WIDTH'(partial[i]) << (WIDTH - 1 - i));
               for (int i = 0; i < N; i++) x = x ^ partial[i];
`ifdef PARITY_CHECK_EN
               e.err = x;
`else
               e.err = 1'b0;
`endif
               exp_q.push_back(e);
               partial.delete();
            end
         end
      end
   endtask

   // Monitor: compare every take against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_word: got %0h expected none", word_data);
            end else begin
               e = exp_q.pop_front();
               check("word_data", 32'(word_data), 32'(e.data));
               check("parity_err", 32'(parity_err), 32'(e.err));
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance
   task automatic send_bit(input logic b);
      int t = 0;
      ser_valid = 1'b1;
      ser_bit   = b;
      while (!ser_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!ser_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ser_ready_timeout: got 0 expected 1");
      end
      @(negedge clk);
      model_step(1'b1, 1'b1, b, 1'b0);
      ser_valid = 1'b0;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input logic flip);
      logic [WIDTH-1:0] v;
      v = w;
      for (int i = WIDTH - 1; i >= 0; i--) send_bit(v[i]);
`ifdef PARITY_CHECK_EN
      send_bit((^v) ^ flip);
`else
      if (flip) send_bit(1'b0);   // unused in this build
`endif
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      partial.delete();
   endtask

   initial begin
      logic rdy;
      int   t;

      // 1: reset
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("ready_in_reset", 32'(ser_ready), 32'd0);
      @(negedge clk);
      do_reset(0);
      @(negedge clk);
      check("rst_word_valid", 32'(word_valid), 32'd0);
      check("rst_word_data", 32'(word_data), 32'd0);
      check("rst_ser_ready", 32'(ser_ready), 32'd1);
      check("rst_parity_err", 32'(parity_err), 32'd0);

      // 2: back to back word with consumer ready
      word_ready = 1'b1;
      send_word(16'hA5C3, 1'b0);
      check("t2_valid_latency", 32'(word_valid), 32'd1);
      check("t2_data", 32'(word_data), 32'hA5C3);
      @(negedge clk);

      // 3: backpressure, second word parks in the shift register
      word_ready = 1'b0;
      @(negedge clk);
      check("t3_empty", 32'(word_valid), 32'd0);
      send_word(16'h1234, 1'b0);
      send_word(16'hBEEF, 1'b0);
      check("t3_ready_drop", 32'(ser_ready), 32'd0);
      check("t3_hold_data", 32'(word_data), 32'h1234);
      repeat (3) @(negedge clk);
      check("t3_still_held", 32'(word_data), 32'h1234);
      check("t3_still_full", 32'(ser_ready), 32'd0);
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
      check("t3_new_data", 32'(word_data), 32'hBEEF);
      check("t3_new_valid", 32'(word_valid), 32'd1);
      check("t3_ready_back", 32'(ser_ready), 32'd1);
      word_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t3_drained", 32'(word_valid), 32'd0);

      // 4: sync drops a partial word
      for (int i = 0; i < 5; i++) send_bit(1'($urandom));
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      model_step(1'b1, 1'b0, 1'b0, 1'b1);
      send_word(16'h00FF, 1'b0);
      check("t4_data", 32'(word_data), 32'h00FF);
      @(negedge clk);
      @(negedge clk);
      check("t4_single_word", 32'(exp_q.size()), 32'd0);

      // 5: reset mid-word
      for (int i = 0; i < 9; i++) send_bit(1'b1);
      do_reset(1);
      @(negedge clk);
      check("t5_no_stale", 32'(word_valid), 32'd0);
      send_word(16'h8001, 1'b0);
      check("t5_data", 32'(word_data), 32'h8001);
      @(negedge clk);

`ifdef PARITY_CHECK_EN
      // 6: parity check
      send_word(16'h0001, 1'b0);
      check("t6_par_ok", 32'(parity_err), 32'd0);
      send_word(16'h0001, 1'b1);
      check("t6_par_bad", 32'(parity_err), 32'd1);
      @(negedge clk);
`endif

      // Randomized traffic with backpressure, gaps and occasional sync
      for (int c = 0; c < 4000; c++) begin
         word_ready = ($urandom_range(0, 3) != 0);
         ser_valid  = ($urandom_range(0, 4) != 0);
         ser_bit    = 1'($urandom);
         sync       = ($urandom_range(0, 80) == 0);
         rdy        = ser_ready;
         @(negedge clk);
         model_step(rdy, ser_valid, ser_bit, sync);
      end
      ser_valid  = 1'b0;
      sync       = 1'b0;
      word_ready = 1'b1;
      t = 0;
      while ((exp_q.size() != 0 || word_valid) && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_valid_low", 32'(word_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
